// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared state encoding and reset pattern for the rotate executor
//
// Purpose : state encoding for rotate_exec and the default pattern loaded at reset.
// Ports   : none (package).

package rot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rot_state_e;

  // Default INIT_PATTERN, resized to WIDTH by the top.
  localparam logic [7:0] ROT_INIT_PATTERN = 8'h01;

  // Width of the step counter; din[3:1] carries N = 0..7.
  localparam int ROT_CNT_W = 3;

endpackage

// File: rtl/rot_prescaler.sv
// rtl/rot_prescaler.sv - free-running step divider with synchronous clear
//
// Purpose : divides the clock by PRESCALE while enabled and emits a one-cycle
//           tick on the last count. The count wraps to zero after each tick.
// Ports   : CLK    in  clock, rising edge
//           RST    in  asynchronous active-low reset
//           clear  in  forces the count to zero at the next edge
//           enable in  count advances only while high
//           tick   out high in the cycle the count equals PRESCALE-1 (and enable)

module rot_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rotate_exec.sv
// rtl/rotate_exec.sv - command-driven bit-pattern rotator (IDLE/SHIFT/DONE)
//
// Purpose : on a rising edge of exactly one of en_left/en_right in IDLE, captures
//           the direction and N = din[3:1], then rotates pattern one bit per step
//           tick N times, pulsing done when finished. Simultaneous rising edges
//           pulse err instead of starting a command.
// Build   : ROT_PRESCALE_EN defined -> one step every PRESCALE cycles via
//           rot_prescaler; undefined -> one step every cycle in SHIFT.
// Ports   : CLK      in  clock, rising edge
//           RST      in  asynchronous active-low reset
//           en_left  in  rotate-left request (level, edge-detected)
//           en_right in  rotate-right request (level, edge-detected)
//           din      in  din[3:1] = rotation count N
//           pattern  out current pattern
//           busy     out high while in SHIFT
//           done     out one-cycle pulse on command completion
//           err      out one-cycle pulse after both requests rose together

module rotate_exec
  import rot_pkg::*;
#(
  parameter int                WIDTH        = 8,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(ROT_INIT_PATTERN),
  parameter int                PRESCALE     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_left,
  input  logic             en_right,
  input  logic [3:0]       din,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
    $error("rotate_exec: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  rot_state_e           state_q, state_d;
  logic                 en_left_q, en_right_q;
  logic                 arm_q;
  logic                 dir_left_q;
  logic [ROT_CNT_W-1:0] cnt_q;
  logic                 err_q;
  logic                 step_tick;

  logic rise_left, rise_right, in_idle, start, both_rise;
  logic [ROT_CNT_W-1:0] n_in;

  assign rise_left  = en_left  & ~en_left_q;
  assign rise_right = en_right & ~en_right_q;
  assign in_idle    = (state_q == ST_IDLE);
  assign n_in       = din[3:1];

  // arm_q stays low for the first cycle after reset release so an enable that
  // was already high during reset is absorbed into en_*_q rather than seen as
  // a fresh rising edge.
  assign start     = in_idle & arm_q & (rise_left ^ rise_right);
  assign both_rise = in_idle & arm_q & rise_left & rise_right;

`ifdef ROT_PRESCALE_EN
  rot_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (start),
    .enable (busy),
    .tick   (step_tick)
  );
`else
  assign step_tick = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (n_in == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        // cnt_q holds rotations still to do, including the one on this tick.
        if (step_tick && (cnt_q == ROT_CNT_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_left_q  <= 1'b0;
      en_right_q <= 1'b0;
      arm_q      <= 1'b0;
      dir_left_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      pattern    <= INIT_PATTERN;
    end else begin
      en_left_q  <= en_left;
      en_right_q <= en_right;
      arm_q      <= 1'b1;
      err_q      <= both_rise;
      if (start) begin
        dir_left_q <= rise_left;
        cnt_q      <= n_in;
      end else if (busy && step_tick) begin
        if (dir_left_q) begin
          pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
        end else begin
          pattern <= {pattern[0], pattern[WIDTH-1:1]};
        end
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_rotate_exec.sv
// tb/tb_rotate_exec.sv - directed self-checking bench for rotate_exec

module tb_rotate_exec;

`ifdef ROT_PRESCALE_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       en_left;
  logic       en_right;
  logic [3:0] din;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  rotate_exec #(
    .WIDTH        (8),
    .INIT_PATTERN (8'h01),
    .PRESCALE     (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en_left  (en_left),
    .en_right (en_right),
    .din      (din),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one command in cycle t and checks busy/done timing, the final
  // pattern, and that an enable edge during the command plus enables held
  // afterwards neither queue nor retrigger anything.
  task automatic cmd(input logic l, input logic r, input logic [3:0] d,
                     input int n, input logic [7:0] exp_pat);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    en_left  = l;
    en_right = r;
    din      = d;
    step();                       // cycle t+1
    din      = ~d;                // late din change must not matter
    en_left  = 1'b1;              // the other enable rises mid-command
    en_right = 1'b1;
    for (int k = 1; k <= n * STEP; k++) begin
      chk("shift_busy", {7'd0, busy}, 8'd1);
      chk("shift_done", {7'd0, done}, 8'd0);
      step();
    end
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("done_busy",  {7'd0, busy}, 8'd0);
    chk("done_err",   {7'd0, err},  8'd0);
    chk("done_pat",   pattern,      exp_pat);
    step();
    chk("after_done", {7'd0, done}, 8'd0);
    chk("after_pat",  pattern,      exp_pat);
    step();
    chk("held_busy",  {7'd0, busy}, 8'd0);
    chk("held_done",  {7'd0, done}, 8'd0);
    chk("held_err",   {7'd0, err},  8'd0);
    en_left  = 1'b0;
    en_right = 1'b0;
    step();
  endtask

  initial begin
    RST      = 1'b0;
    en_left  = 1'b0;
    en_right = 1'b0;
    din      = 4'h0;
    step();
    step();
    chk("rst_pat",  pattern,      8'h01);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_err",  {7'd0, err},  8'd0);
    RST = 1'b1;
    step();
    step();

    // left N=3: 01 -> 08
    cmd(1'b1, 1'b0, 4'b0110, 3, 8'h08);
    // right N=1: 08 -> 04
    cmd(1'b0, 1'b1, 4'b0010, 1, 8'h04);

    // both rise together: err pulse only
    en_left  = 1'b1;
    en_right = 1'b1;
    din      = 4'b0110;
    step();
    chk("err_pulse", {7'd0, err},  8'd1);
    chk("err_busy",  {7'd0, busy}, 8'd0);
    chk("err_pat",   pattern,      8'h04);
    step();
    chk("err_clear", {7'd0, err},  8'd0);
    chk("err_busy2", {7'd0, busy}, 8'd0);
    chk("err_done",  {7'd0, done}, 8'd0);
    en_left  = 1'b0;
    en_right = 1'b0;
    step();

    // left N=5: 04 -> 80
    cmd(1'b1, 1'b0, 4'b1010, 5, 8'h80);

    // left N=7 aborted by reset in cycle t+3, enable held through release
    en_left = 1'b1;
    din     = 4'b1110;
    step();
    chk("abort_busy", {7'd0, busy}, 8'd1);
    step();
    step();
    RST = 1'b0;
    #1;
    chk("abort_pat",  pattern,      8'h01);
    chk("abort_busy0",{7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    step();
    step();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rel_busy", {7'd0, busy}, 8'd0);
      chk("rel_done", {7'd0, done}, 8'd0);
      chk("rel_pat",  pattern,      8'h01);
    end
    en_left = 1'b0;
    step();

    // right N=1: 01 -> 80
    cmd(1'b0, 1'b1, 4'b0010, 1, 8'h80);
    // right N=0: done next cycle, pattern kept
    cmd(1'b0, 1'b1, 4'b0001, 0, 8'h80);
    // left N=7: 80 -> 40
    cmd(1'b1, 1'b0, 4'b1111, 7, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
